mux4_rr_arb: RTL and testbench

Round-robin arbiter and burst sequencer that shares one DATA_W-wide 4:1 multiplexed channel among four valid/ready sources. It grants one source at a time and drives the mux select. It holds the grant until that source's burst ends, then rotates priority. It sits between four producer blocks and a single downstream consumer.

---
 rtl/mux4_rr_pkg.sv | 25 ++
 rtl/mux4to1_w.sv | 27 ++
 rtl/mux4_rr_arb.sv | 103 ++++++++++
 tb/tb_mux4_rr_arb.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_rr_pkg.sv
// Shared types, sizes and the round-robin priority scan for the 4-source
// arbiter.
package mux4_rr_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // Returns the first requesting index at or after ptr, wrapping mod N_REQ.
  // Scanning offsets from high to low lets the smallest offset win last.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] idx;
    rr_pick = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux4to1_w.sv
// DATA_W-wide 4:1 multiplexer used for the shared data channel.
module mux4to1_w
  import mux4_rr_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  output logic [DATA_W-1:0] y
);

  // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
  always_comb begin
    y = '0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      2'd3:    y = d3;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arb.sv
// Round-robin arbiter and burst sequencer sharing one 4:1 muxed valid/ready
// channel among four sources; a grant is held until its burst ends.
module mux4_rr_arb
  import mux4_rr_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_REQ-1:0]  i_valid,
  input  logic [N_REQ-1:0]  i_last,
  input  logic [DATA_W-1:0] i_data0,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic [DATA_W-1:0] i_data3,
  output logic [N_REQ-1:0]  o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  input  logic              i_ready,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_busy
);

  localparam int                CNT_W    = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // NOTE: the reset branch covers every register; nothing here is a memory array.
  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    o_busy  = 1'b0;
    o_valid = 1'b0;
    o_ready = '0;
    o_last  = 1'b0;

    case (state_q)
      IDLE: begin
        if (|i_valid) begin
          sel_d   = rr_pick(i_valid, ptr_q);
          ptr_d   = sel_d + SEL_W'(1);
          cnt_d   = '0;
          state_d = GRANT;
        end
      end

      GRANT: begin
        o_busy         = 1'b1;
        o_valid        = i_valid[sel_q];
        o_ready[sel_q] = i_ready;
        // The beat at the burst cap is forced last so one source cannot hog the channel.
        o_last         = i_last[sel_q] | (cnt_q == CNT_LAST);
        if (o_valid && i_ready) begin
          if (o_last) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_sel = sel_q;

  mux4to1_w #(
    .DATA_W(DATA_W)
  ) u_data_mux (
    .sel(sel_q),
    .d0 (i_data0),
    .d1 (i_data1),
    .d2 (i_data2),
    .d3 (i_data3),
    .y  (o_data)
  );

endmodule

// File: tb/tb_mux4_rr_arb.sv
// Self-checking bench for mux4_rr_arb: scripted scenarios plus randomized
// traffic against a cycle-level behavioural model of the arbitration rules.
module tb_mux4_rr_arb;

  localparam int DW = 8;
  localparam int MB = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [3:0]    i_valid;
  logic [3:0]    i_last;
  logic          i_ready;
  logic [DW-1:0] d [4];

  logic [3:0]    o_ready;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic [1:0]    o_sel;
  logic          o_busy;

  logic [3:0]    b1_ready;
  logic          b1_valid;
  logic [DW-1:0] b1_data;
  logic          b1_last;
  logic [1:0]    b1_sel;
  logic          b1_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  mux4_rr_arb #(.DATA_W(DW), .MAX_BURST(MB)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .i_last (i_last),
    .i_data0(d[0]),
    .i_data1(d[1]),
    .i_data2(d[2]),
    .i_data3(d[3]),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .o_data (o_data),
    .o_last (o_last),
    .i_ready(i_ready),
    .o_sel  (o_sel),
    .o_busy (o_busy)
  );

  // Single-beat-cap instance: every granted beat must be flagged last.
  mux4_rr_arb #(.DATA_W(DW), .MAX_BURST(1)) dut1 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .i_last (i_last),
    .i_data0(d[0]),
    .i_data1(d[1]),
    .i_data2(d[2]),
    .i_data3(d[3]),
    .o_ready(b1_ready),
    .o_valid(b1_valid),
    .o_data (b1_data),
    .o_last (b1_last),
    .i_ready(i_ready),
    .o_sel  (b1_sel),
    .o_busy (b1_busy)
  );

  wire [16:0] act = {o_busy, o_valid, o_ready, o_last, o_sel, o_data};

  // Behavioural model: who owns the channel, where priority starts, beats so far.
  bit m_busy;
  int m_sel;
  int m_ptr;
  int m_cnt;

  function automatic logic [16:0] expected();
    logic [3:0] r;
    logic       l;
    r = '0;
    if (m_busy) begin
      r[m_sel] = i_ready;
      l = i_last[m_sel] | (m_cnt == MB - 1);
      return {1'b1, i_valid[m_sel], r, l, 2'(m_sel), d[m_sel]};
    end
    return {1'b0, 1'b0, 4'b0000, 1'b0, 2'(m_sel), d[m_sel]};
  endfunction

  function automatic bit model_beat();
    return m_busy && i_valid[m_sel] && i_ready;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_sel  = 0;
    m_ptr  = 0;
    m_cnt  = 0;
  endtask

  task automatic model_update();
    int idx;
    if (!m_busy) begin
      if (i_valid != 4'b0000) begin
        idx = -1;
        for (int k = 0; k < 4; k++)
          if (idx < 0 && i_valid[(m_ptr + k) % 4]) idx = (m_ptr + k) % 4;
        m_sel  = idx;
        m_ptr  = (idx + 1) % 4;
        m_cnt  = 0;
        m_busy = 1;
      end
    end else if (model_beat()) begin
      if (i_last[m_sel] || m_cnt == MB - 1) begin
        m_busy = 0;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_valid = '0;
    i_last  = '0;
    i_ready = 1'b0;
    i_rst   = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
  endtask

  task automatic rand_data();
    for (int k = 0; k < 4; k++) d[k] = DW'($urandom);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    rand_data();
    i_valid = 4'b1111;
    i_last  = 4'b1111;
    i_ready = 1'b1;
    #1;
    n_checks++;
    if (act !== {1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, d[0]}) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h expected %h", act, {1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, d[0]});
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    rand_data();
    i_valid = 4'b0100;
    i_ready = 1'b1;
    #1;
    n_checks++;
    if (act !== expected() || o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL single_idle: got %h expected %h", act, expected());
    end
    step();
    for (int beat = 1; beat <= 3; beat++) begin
      rand_data();
      i_last = (beat == 3) ? 4'b0100 : 4'b0000;
      #1;
      n_checks++;
      if (act !== expected() || o_sel !== 2'd2 || o_busy !== 1'b1 || o_last !== (beat == 3)) begin
        n_errors++;
        $display("FAIL single_beat%0d: got %h expected %h", beat, act, expected());
      end
      step();
    end
    i_valid = '0;
    i_last  = '0;
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || act !== expected()) begin
      n_errors++;
      $display("FAIL single_return_idle: got %h expected %h", act, expected());
    end
    step();
  endtask

  task automatic test_fairness();
    do_reset();
    i_valid = 4'b1111;
    i_last  = 4'b1111;
    i_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      rand_data();
      #1;
      n_checks++;
      if (act !== expected() || o_busy !== c[0] || (c[0] && o_sel !== 2'((c / 2) % 4))) begin
        n_errors++;
        $display("FAIL fairness_cycle%0d: got %h expected %h", c, act, expected());
      end
      step();
    end
  endtask

  task automatic test_max_burst();
    int sent;
    int cur;
    int grants[$];
    do_reset();
    i_ready = 1'b1;
    sent = 0;
    cur  = 0;
    for (int c = 0; c < 40 && (sent < 10 || m_busy); c++) begin
      rand_data();
      i_valid = (sent < 10) ? 4'b0010 : 4'b0000;
      i_last  = (sent == 9) ? 4'b0010 : 4'b0000;
      #1;
      n_checks++;
      if (act !== expected()) begin
        n_errors++;
        $display("FAIL max_burst_cycle%0d: got %h expected %h", c, act, expected());
      end
      if (model_beat()) begin
        sent++;
        cur++;
        n_checks++;
        if (o_last !== (sent == 4 || sent == 8 || sent == 10)) begin
          n_errors++;
          $display("FAIL max_burst_last_beat%0d: got %b expected %b", sent, o_last,
                   (sent == 4 || sent == 8 || sent == 10));
        end
        if (o_last === 1'b1) begin
          grants.push_back(cur);
          cur = 0;
        end
      end
      step();
    end
    n_checks++;
    if (grants.size() != 3 || grants[0] != 4 || grants[1] != 4 || grants[2] != 2 || sent != 10) begin
      n_errors++;
      $display("FAIL max_burst_grants: got %0d grants, %0d beats, expected 3 grants (4,4,2), 10 beats",
               grants.size(), sent);
    end
    i_valid = '0;
    i_last  = '0;
  endtask

  task automatic test_backpressure();
    // Per cycle: {valid3, ready, last3}
    logic [2:0] tbl [7] = '{3'b110, 3'b100, 3'b010, 3'b010, 3'b100, 3'b110, 3'b111};
    do_reset();
    i_valid = 4'b1000;
    i_ready = 1'b1;
    #1;
    step();
    for (int c = 0; c < 7; c++) begin
      rand_data();
      i_valid = {tbl[c][2], 2'b00, 1'b1};
      i_ready = tbl[c][1];
      i_last  = {tbl[c][0], 3'b000};
      #1;
      n_checks++;
      if (act !== expected() || o_sel !== 2'd3 || o_busy !== 1'b1 || o_ready[0] !== 1'b0 ||
          o_ready[3] !== tbl[c][1]) begin
        n_errors++;
        $display("FAIL backpressure_cycle%0d: got %h expected %h", c, act, expected());
      end
      step();
    end
    i_ready = 1'b1;
    i_last  = 4'b0000;
    i_valid = 4'b0001;
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || act !== expected()) begin
      n_errors++;
      $display("FAIL backpressure_release: got %h expected %h", act, expected());
    end
    step();
    #1;
    n_checks++;
    if (o_busy !== 1'b1 || o_sel !== 2'd0 || act !== expected()) begin
      n_errors++;
      $display("FAIL backpressure_next_grant: got %h expected %h", act, expected());
    end
    step();
    do_reset();
  endtask

  task automatic test_async_reset();
    do_reset();
    rand_data();
    i_valid = 4'b0100;
    i_ready = 1'b1;
    #1;
    step();
    #1;
    step();
    #1;
    n_checks++;
    if (act !== expected() || o_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL async_before: got %h expected %h", act, expected());
    end
    #2;
    i_rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (act !== {1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, d[0]}) begin
      n_errors++;
      $display("FAIL async_reset_now: got %h expected %h", act, {1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, d[0]});
    end
    @(negedge i_clk);
    i_rst   = 1'b0;
    i_valid = 4'b1010;
    #1;
    n_checks++;
    if (act !== expected()) begin
      n_errors++;
      $display("FAIL async_idle: got %h expected %h", act, expected());
    end
    step();
    #1;
    n_checks++;
    if (o_sel !== 2'd1 || o_busy !== 1'b1 || act !== expected()) begin
      n_errors++;
      $display("FAIL async_rearb_from_ptr0: got %h expected %h", act, expected());
    end
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rand_data();
      i_valid = 4'($urandom);
      i_last  = 4'($urandom) & 4'($urandom);
      i_ready = ($urandom_range(3) != 0);
      #1;
      n_checks++;
      if (act !== expected()) begin
        n_errors++;
        $display("FAIL random_cycle%0d: got %h expected %h", c, act, expected());
      end
      n_checks++;
      if (b1_last !== b1_busy) begin
        n_errors++;
        $display("FAIL maxburst1_last_cycle%0d: got %b expected %b", c, b1_last, b1_busy);
      end
      step();
    end
  endtask

  initial begin
    i_rst   = 1'b1;
    i_valid = '0;
    i_last  = '0;
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) d[k] = '0;
    model_reset();
    @(negedge i_clk);
    test_reset();
    test_single();
    test_fairness();
    test_max_burst();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
